// File: rtl/max_pool_stream_if.sv
// max_pool_stream_if: handshake bundle for max_pool_stream.
//   Y/in_valid/in_ready   : whole-map input handshake (Y is R_Y*C_Y signed elements, row-major)
//   out_*                 : pooled result handshake, one element per window, out_last on final window
//   busy                  : block is not idle
// Modports: slave = the pooling block, master = the side feeding maps and taking results.
interface max_pool_stream_if #(
    parameter int In_d_W = 32,
    parameter int R_Y    = 3,
    parameter int C_Y    = 3,
    parameter int K      = 2,
    parameter int S      = 1
);
    localparam int R_O  = (R_Y - K) / S + 1;
    localparam int C_O  = (C_Y - K) / S + 1;
    localparam int RowW = $clog2(R_O + 1);
    localparam int ColW = $clog2(C_O + 1);

    logic [In_d_W*R_Y*C_Y-1:0] Y;
    logic                      in_valid;
    logic                      in_ready;
    logic [In_d_W-1:0]         out_data;
    logic [RowW-1:0]           out_row;
    logic [ColW-1:0]           out_col;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;
    logic                      busy;

    modport slave (
        input  Y, in_valid, out_ready,
        output in_ready, out_data, out_row, out_col, out_valid, out_last, busy
    );

    modport master (
        output Y, in_valid, out_ready,
        input  in_ready, out_data, out_row, out_col, out_valid, out_last, busy
    );
endinterface

// File: rtl/max_pool_stream.sv
// max_pool_stream: streaming KxK / stride-S max pooling over a captured R_Y x C_Y signed map.
// A map is captured whole in IDLE, then each output window is scanned one element per enabled
// edge (SCAN) and presented on the result handshake (EMIT) until the last window is taken.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset (overrides clk_en)
//   clk_en  : global advance enable; 0 freezes all state
//   bus_io  : max_pool_stream_if.slave (map input, result output, busy)
// Optional feature: define POOL_RELU_EN to clamp negative elements to 0 before comparing.
module max_pool_stream #(
    parameter int In_d_W = 32,
    parameter int R_Y    = 3,
    parameter int C_Y    = 3,
    parameter int K      = 2,
    parameter int S      = 1
) (
    input logic              clk,
    input logic              rst,
    input logic              clk_en,
    max_pool_stream_if.slave bus_io
);
    localparam int R_O   = (R_Y - K) / S + 1;
    localparam int C_O   = (C_Y - K) / S + 1;
    localparam int RowW  = $clog2(R_O + 1);
    localparam int ColW  = $clog2(C_O + 1);
    localparam int KW    = $clog2(K + 1);
    localparam int NumEl = R_Y * C_Y;
    localparam int IdxW  = (NumEl > 1) ? $clog2(NumEl) : 1;

    typedef enum logic [1:0] {StIdle, StScan, StEmit} state_e;

    state_e                   state_q, state_d;
    logic signed [In_d_W-1:0] map_q [NumEl];
    logic signed [In_d_W-1:0] map_d [NumEl];
    logic [RowW-1:0]          wr_q, wr_d;
    logic [ColW-1:0]          wc_q, wc_d;
    logic [KW-1:0]            ki_q, ki_d;
    logic [KW-1:0]            kj_q, kj_d;
    logic signed [In_d_W-1:0] max_q, max_d;

    logic [IdxW-1:0]          idx;
    logic signed [In_d_W-1:0] elem;
    logic                     last_win;

    assign last_win = (wr_q == RowW'(R_O - 1)) && (wc_q == ColW'(C_O - 1));

    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        wr_d    = wr_q;
        wc_d    = wc_q;
        ki_d    = ki_q;
        kj_d    = kj_q;
        max_d   = max_q;

        // Map element under the scan cursor: window origin (wr*S, wc*S) plus offset (ki, kj).
        idx  = IdxW'((int'(wr_q) * S + int'(ki_q)) * C_Y + int'(wc_q) * S + int'(kj_q));
        elem = map_q[idx];
`ifdef POOL_RELU_EN
        if (elem[In_d_W-1]) begin
            elem = '0;
        end
`endif

        case (state_q)
            StIdle: begin
                if (bus_io.in_valid) begin
                    for (int i = 0; i < NumEl; i++) begin
                        map_d[i] = bus_io.Y[i*In_d_W +: In_d_W];
                    end
                    wr_d    = '0;
                    wc_d    = '0;
                    ki_d    = '0;
                    kj_d    = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (ki_q == '0 && kj_q == '0) begin
                    max_d = elem;
                end else if (elem > max_q) begin
                    max_d = elem;
                end
                if (kj_q == KW'(K - 1)) begin
                    kj_d = '0;
                    if (ki_q == KW'(K - 1)) begin
                        ki_d    = '0;
                        state_d = StEmit;
                    end else begin
                        ki_d = ki_q + 1'b1;
                    end
                end else begin
                    kj_d = kj_q + 1'b1;
                end
            end
            StEmit: begin
                if (bus_io.out_ready) begin
                    if (last_win) begin
                        wr_d    = '0;
                        wc_d    = '0;
                        state_d = StIdle;
                    end else begin
                        state_d = StScan;
                        if (wc_q == ColW'(C_O - 1)) begin
                            wc_d = '0;
                            wr_d = wr_q + 1'b1;
                        end else begin
                            wc_d = wc_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wr_q    <= '0;
            wc_q    <= '0;
            ki_q    <= '0;
            kj_q    <= '0;
            max_q   <= '0;
            for (int i = 0; i < NumEl; i++) begin
                map_q[i] <= '0;
            end
        end else if (clk_en) begin
            state_q <= state_d;
            wr_q    <= wr_d;
            wc_q    <= wc_d;
            ki_q    <= ki_d;
            kj_q    <= kj_d;
            max_q   <= max_d;
            map_q   <= map_d;
        end
    end

    assign bus_io.in_ready  = (state_q == StIdle);
    assign bus_io.busy      = (state_q != StIdle);
    assign bus_io.out_valid = (state_q == StEmit);
    assign bus_io.out_last  = (state_q == StEmit) && last_win;
    assign bus_io.out_data  = max_q;
    assign bus_io.out_row   = wr_q;
    assign bus_io.out_col   = wc_q;
endmodule

// File: tb/tb_max_pool_stream.sv
module tb_max_pool_stream;
    localparam int W    = 32;
    localparam int RY   = 3;
    localparam int CY   = 3;
    localparam int KK   = 2;
    localparam int SS   = 1;
    localparam int RO   = (RY - KK) / SS + 1;
    localparam int CO   = (CY - KK) / SS + 1;
    localparam int YW   = W * RY * CY;
    localparam int RowW = $clog2(RO + 1);
    localparam int ColW = $clog2(CO + 1);

    typedef struct packed {
        logic signed [W-1:0] data;
        logic [RowW-1:0]     row;
        logic [ColW-1:0]     col;
        logic                last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    always #5 clk = ~clk;

    max_pool_stream_if #(.In_d_W(W), .R_Y(RY), .C_Y(CY), .K(KK), .S(SS)) bus ();

    max_pool_stream #(.In_d_W(W), .R_Y(RY), .C_Y(CY), .K(KK), .S(SS)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus_io (bus.slave)
    );

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   n_captured = 0;
    bit   rand_mode  = 1'b0;

    function automatic void check(input bit ok, input string name, input string act,
                                  input string req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s", name, act, req);
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("%0d@(%0d,%0d) last=%0d", e.data, e.row, e.col, e.last);
    endfunction

    // Reference: pool every window of the map directly with nested loops.
    function automatic void push_expected(input logic [YW-1:0] y);
        for (int wr = 0; wr < RO; wr++) begin
            for (int wc = 0; wc < CO; wc++) begin
                longint best;
                exp_t e;
                best = 0;
                for (int ki = 0; ki < KK; ki++) begin
                    for (int kj = 0; kj < KK; kj++) begin
                        logic signed [W-1:0] el;
                        longint v;
                        el = y[((wr * SS + ki) * CY + wc * SS + kj) * W +: W];
                        v  = el;
`ifdef POOL_RELU_EN
                        if (v < 0) v = 0;
`endif
                        if ((ki == 0 && kj == 0) || v > best) best = v;
                    end
                end
                e.data = best[W-1:0];
                e.row  = wr[RowW-1:0];
                e.col  = wc[ColW-1:0];
                e.last = (wr == RO - 1) && (wc == CO - 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    function automatic logic [YW-1:0] map_from(input int m[RY*CY]);
        logic [YW-1:0] y;
        for (int i = 0; i < RY * CY; i++) y[i*W +: W] = m[i];
        return y;
    endfunction

    function automatic logic [YW-1:0] rand_map();
        logic [YW-1:0] y;
        bit wide;
        wide = ($urandom_range(0, 1) == 1);
        for (int i = 0; i < RY * CY; i++) begin
            int v;
            if (wide) v = int'($urandom());
            else v = int'($urandom_range(0, 20)) - 10;
            y[i*W +: W] = v;
        end
        return y;
    endfunction

    // Capture side of the scoreboard: a map taken by the DUT queues its expected results.
    initial forever begin
        @(negedge clk);
        if (!rst && clk_en && bus.in_valid && bus.in_ready) begin
            push_expected(bus.Y);
            n_captured++;
        end
    end

    // Monitor: pops on every completed result handshake; also checks holding while stalled.
    exp_t mon_act, mon_prev, mon_exp;
    bit   mon_hold = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            mon_hold = 1'b0;
        end else if (bus.out_valid) begin
            mon_act.data = bus.out_data;
            mon_act.row  = bus.out_row;
            mon_act.col  = bus.out_col;
            mon_act.last = bus.out_last;
            if (mon_hold) check(mon_act == mon_prev, "hold_stable", fmt(mon_act), fmt(mon_prev));
            if (bus.out_ready && clk_en) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_output", fmt(mon_act), "no output");
                end else begin
                    mon_exp = exp_q.pop_front();
                    check(mon_act == mon_exp, "pool_result", fmt(mon_act), fmt(mon_exp));
                end
                mon_hold = 1'b0;
            end else begin
                mon_hold = 1'b1;
                mon_prev = mon_act;
            end
        end else if (mon_hold) begin
            check(1'b0, "hold_valid", "out_valid=0", "out_valid=1");
            mon_hold = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            clk_en        = ($urandom_range(0, 9) < 8);
        end
    endtask

    task automatic send_map(input logic [YW-1:0] y);
        int guard;
        guard        = 0;
        bus.Y        = y;
        bus.in_valid = 1'b1;
        while (!(bus.in_ready && clk_en) && guard < 500) begin
            tick();
            guard++;
        end
        check(guard < 500, "capture_timeout", $sformatf("%0d cycles", guard), "< 500");
        tick();
        bus.in_valid = 1'b0;
        bus.Y        = rand_map();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((bus.busy || exp_q.size() != 0) && guard < 3000) begin
            tick();
            guard++;
        end
        check(guard < 3000, "idle_timeout", $sformatf("%0d cycles", guard), "< 3000");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int m29[RY*CY] = '{1, -5, 3, 4, 2, -7, -1, 0, 9};
    int m30[RY*CY] = '{-3, -3, -3, -3, -3, -3, -3, -3, -3};

    initial begin
        int n;
        int caps0;
        rst           = 1'b1;
        clk_en        = 1'b0;
        bus.Y         = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        clk_en = 1'b1;
        check(bus.in_ready == 1'b1 && bus.busy == 1'b0, "reset_ready_busy",
              $sformatf("ready=%0b busy=%0b", bus.in_ready, bus.busy), "ready=1 busy=0");
        check(bus.out_valid == 1'b0 && bus.out_last == 1'b0, "reset_valid_last",
              $sformatf("valid=%0b last=%0b", bus.out_valid, bus.out_last), "valid=0 last=0");
        check(bus.out_data == '0 && bus.out_row == '0 && bus.out_col == '0, "reset_data",
              $sformatf("%0d@(%0d,%0d)", bus.out_data, bus.out_row, bus.out_col), "0@(0,0)");

        // Reference map, full throughput; first result five edges after capture.
        send_map(map_from(m29));
        wait_valid(n);
        check(n + 1 == 5, "first_valid_latency", $sformatf("%0d edges", n + 1), "5 edges");
        wait_idle();

        // All-negative map.
        send_map(map_from(m30));
        wait_idle();

        // Back-pressure at first EMIT for six cycles.
        bus.out_ready = 1'b0;
        send_map(map_from(m29));
        wait_valid(n);
        for (int i = 0; i < 6; i++) begin
            tick();
            check(bus.out_valid && $signed(bus.out_data) == 4 && bus.out_row == '0
                  && bus.out_col == '0, "stall_hold",
                  $sformatf("v=%0b %0d@(%0d,%0d)", bus.out_valid, $signed(bus.out_data),
                            bus.out_row, bus.out_col), "v=1 4@(0,0)");
        end
        bus.out_ready = 1'b1;
        wait_idle();

        // Reset two edges into the scan of window (0,1).
        send_map(map_from(m29));
        wait_valid(n);
        tick();
        tick();
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check(bus.out_valid == 1'b0 && bus.busy == 1'b0 && bus.in_ready == 1'b1, "mid_reset",
              $sformatf("valid=%0b busy=%0b ready=%0b", bus.out_valid, bus.busy, bus.in_ready),
              "valid=0 busy=0 ready=1");
        send_map(rand_map());
        wait_idle();

        // Three disabled cycles mid-scan delay the first result by three.
        send_map(map_from(m29));
        tick();
        tick();
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check(bus.busy && !bus.out_valid, "freeze",
                  $sformatf("busy=%0b valid=%0b", bus.busy, bus.out_valid), "busy=1 valid=0");
        end
        clk_en = 1'b1;
        wait_valid(n);
        check(1 + 2 + 3 + n == 8, "stalled_latency", $sformatf("%0d edges", 1 + 2 + 3 + n),
              "8 edges");
        wait_idle();

        // in_valid held with Y churning: captures only at edges 1 and 22 of 25.
        caps0        = n_captured;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 25; i++) begin
            bus.Y = rand_map();
            tick();
        end
        bus.in_valid = 1'b0;
        check(n_captured - caps0 == 2, "held_valid_captures",
              $sformatf("%0d", n_captured - caps0), "2");
        wait_idle();

        // Randomised maps with random back-pressure and enable gaps.
        rand_mode = 1'b1;
        for (int i = 0; i < 20; i++) send_map(rand_map());
        wait_idle();
        rand_mode     = 1'b0;
        clk_en        = 1'b1;
        bus.out_ready = 1'b1;
        tick();

        check(exp_q.size() == 0, "scoreboard_drained", $sformatf("%0d left", exp_q.size()),
              "0 left");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/max_pool_stream.md
MAX_POOL_STREAM -- requirements
Module: max_pool_stream

Interface
REQ-001 SHALL have parameter In_d_W, default 32, meaning signed element width of the convolution map.
REQ-002 SHALL have parameter R_Y, default 3, meaning input map rows.
REQ-003 SHALL have parameter C_Y, default 3, meaning input map columns.
REQ-004 SHALL have parameter K, default 2, meaning square pool window size; K <= R_Y and K <= C_Y.
REQ-005 SHALL have parameter S, default 1, meaning pool stride; output dims R_O=(R_Y-K)/S+1, C_O=(C_Y-K)/S+1.
REQ-006 SHALL have port clk, input, 1 bit; single clock, all logic rising-edge.
REQ-007 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-008 SHALL have port clk_en, input, 1 bit; global advance enable.
REQ-009 SHALL have port Y, input, In_d_W*R_Y*C_Y bits; conv map, element (r,c) at bits [(r*C_Y+c)*In_d_W +: In_d_W], two's complement.
REQ-010 SHALL have port in_valid, input, 1 bit; Y holds a complete map.
REQ-011 SHALL have port in_ready, output, 1 bit; block can capture a map.
REQ-012 SHALL have port out_data, output, In_d_W bits; pooled value.
REQ-013 SHALL have port out_row and out_col, outputs, $clog2(R_O+1) and $clog2(C_O+1) bits; pooled element coordinates.
REQ-014 SHALL have port out_valid, input out_ready, output out_last, 1 bit each; result handshake, last of map.
REQ-015 SHALL have port busy, output, 1 bit; high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, EMIT.
REQ-017 In IDLE, in_ready SHALL be 1; map captured into internal register on edge with in_valid=1, clk_en=1; next state SCAN, window (0,0), element counter 0.
REQ-018 Y SHALL be sampled only at the capture edge; later Y changes SHALL NOT affect results.
REQ-019 SCAN SHALL process one window element per edge, row-major within window, window origin (wr*S, wc*S); first element loads running max, others replace it when strictly greater (signed compare).
REQ-020 After K*K SCAN edges, state SHALL become EMIT with out_valid=1; first out_valid visible after K*K+1 edges counting the capture edge.
REQ-021 In EMIT, out_data/out_row/out_col/out_last SHALL stay stable while out_ready=0.
REQ-022 On EMIT edge with out_ready=1: if last window (R_O-1,C_O-1), go IDLE; else advance wc (wrapping to 0 and incrementing wr at C_O-1) and return to SCAN.
REQ-023 out_last SHALL be 1 only in EMIT for window (R_O-1,C_O-1).
REQ-024 in_valid outside IDLE SHALL be ignored (in_ready=0).
REQ-025 clk_en=0 SHALL freeze all state and outputs; handshakes complete only on clk_en=1 edges.

Reset
REQ-026 On rst=1 edge (regardless of clk_en or state, including mid-SCAN/EMIT): state IDLE, counters 0, running max 0, out_data 0, out_row/out_col 0, out_valid 0, out_last 0, busy 0, in_ready 1 next cycle; partial map discarded.

Configuration
REQ-027 Macro POOL_RELU_EN defined: each element SHALL pass through ReLU (negative -> 0) before compare, so out_data >= 0.
REQ-028 Macro POOL_RELU_EN undefined: raw signed max SHALL be output; no other behaviour change, identical latency.

Verification
REQ-029 Y=[1,-5,3;4,2,-7;-1,0,9], K=2,S=1, out_ready=1 -> outputs 4@(0,0),3@(0,1),4@(1,0),9@(1,1); out_last only on 9; first out_valid 5 edges after capture.
REQ-030 Y all -3 -> four outputs 0 with POOL_RELU_EN, -3 without.
REQ-031 Same map as REQ-029, out_ready=0 for 6 cycles at first EMIT -> out_data 4, out_row 0, out_col 0 held stable; continues normally after.
REQ-032 rst pulsed 2 edges into SCAN of window (0,1) -> out_valid 0, busy 0, in_ready 1; new map accepted and pooled correctly from (0,0).
REQ-033 clk_en=0 for 3 cycles mid-SCAN -> no state change; results identical to REQ-029, delayed 3 cycles.
REQ-034 in_valid held high through processing with Y changed after capture -> output unaffected; second map captured only after returning to IDLE.
